fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter LAST_ADDR, default 23: highest valid instruction address.
REQ-002 Parameter HALT_OP, default 4'hF: opcode (instr[15:12]) that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin fetching at address 0; honoured only in IDLE or HALT.
REQ-006 stall  input  1  freeze pc, outputs and counters this cycle.
REQ-007 br_valid  input  1  redirect request, sampled only in RUN.
REQ-008 br_target  input  13  redirect address.
REQ-009 instr_in  input  16  instruction returned combinationally by instruction memory for current pc.
REQ-010 pc  output  13  address driven to instruction memory (registered).
REQ-011 instr_out  output  16  issued instruction (registered).
REQ-012 instr_pc  output  13  address of instr_out.
REQ-013 instr_valid  output  1  instr_out valid this cycle.
REQ-014 busy  output  1  high exactly while in RUN.
REQ-015 halted  output  1  high exactly while in HALT.
REQ-016 err  output  1  sticky: a redirect targeted an address above LAST_ADDR.
REQ-017 fetch_cnt  output  16  number of instructions issued since last start.

Function
REQ-018 FSM states SHALL be IDLE, RUN, HALT (IDLE is the reset state).
REQ-019 IDLE/HALT with start=1 SHALL go to RUN next cycle with pc=0, fetch_cnt=0, err=0, instr_valid=0.
REQ-020 In RUN, per-cycle priority SHALL be: stall > br_valid > halt detect > end-of-program > increment.
REQ-021 stall=1 in RUN SHALL hold pc, instr_out, instr_pc, instr_valid, fetch_cnt and state unchanged; br_valid is ignored that cycle.
REQ-022 Normal RUN cycle SHALL register instr_out=instr_in, instr_pc=pc, instr_valid=1, fetch_cnt+1, pc+1 (one-cycle fetch latency).
REQ-023 br_valid=1 (no stall) with br_target<=LAST_ADDR SHALL load pc=br_target and drive instr_valid=0 next cycle (one bubble; instr_in discarded, not counted).
REQ-024 br_valid=1 with br_target>LAST_ADDR SHALL set err=1, instr_valid=0, go to HALT, pc unchanged.
REQ-025 instr_in[15:12]==HALT_OP (no stall, no branch) SHALL issue that instruction (valid, counted), hold pc, and go to HALT.
REQ-026 pc==LAST_ADDR (no stall, no branch, not halt op) SHALL issue the instruction, hold pc at LAST_ADDR, and go to HALT; pc SHALL never exceed LAST_ADDR.
REQ-027 In IDLE and HALT, instr_valid SHALL be 0 from the cycle after entry; pc, instr_out, instr_pc hold.
REQ-028 fetch_cnt SHALL saturate at 16'hFFFF.
REQ-029 start, stall, br_valid outside their qualifying states SHALL have no effect.
REQ-030 busy and halted SHALL be decoded from registered state only.

Reset
REQ-031 rst=1 at a rising edge SHALL force IDLE, pc=0, instr_out=0, instr_pc=0, instr_valid=0, fetch_cnt=0, err=0, regardless of any other input, including mid-RUN and during stall.
REQ-032 rst SHALL take priority over start in the same cycle.

Verification
REQ-033 Reset, start, memory of 24 NOPs (16'h0000) -> instr_pc 0..23 valid on consecutive cycles, then halted=1, pc=23, fetch_cnt=24.
REQ-034 Running, stall held 3 cycles at pc=5 -> pc, instr_out, fetch_cnt frozen 3 cycles, br_valid pulse during stall ignored, resumes at pc=5.
REQ-035 At pc=4, br_valid=1, br_target=12 -> next cycle pc=12, instr_valid=0; following cycle instr_pc=12 valid; address 4 never counted.
REQ-036 Instruction 16'hF123 at address 7 -> issued with instr_pc=7, halted=1, pc stays 7, fetch_cnt=8; later start restarts at pc=0 with fetch_cnt=0.
REQ-037 br_target=30 -> err=1, halted=1, instr_valid=0; next start clears err.
REQ-038 rst asserted mid-RUN together with start -> IDLE, all outputs at reset values, no fetch until a later start.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the program counter through instruction memory,
// issues one instruction per cycle, and handles stall, redirect and halt conditions.
module fetch_sequencer #(
  parameter int         LAST_ADDR = 23,
  parameter logic [3:0] HALT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [12:0] br_target,
  input  logic [15:0] instr_in,
  output logic [12:0] pc,
  output logic [15:0] instr_out,
  output logic [12:0] instr_pc,
  output logic        instr_valid,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] fetch_cnt
);

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_cnt   <= '0;
      err         <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          instr_valid <= 1'b0;
          if (start) begin
            state     <= RUN;
            pc        <= '0;
            fetch_cnt <= '0;
            err       <= 1'b0;
          end
        end
        RUN: begin
          if (stall) begin
            // Everything holds; a redirect presented during a stall is dropped.
          end else if (br_valid) begin
            instr_valid <= 1'b0;
            if (br_target > LAST_PC) begin
              err   <= 1'b1;
              state <= HALT;
            end else begin
              pc <= br_target;
            end
          end else begin
            instr_out   <= instr_in;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            fetch_cnt   <= sat_inc(fetch_cnt);
            // Halt opcode or end of program: issue this one, park pc, stop.
            if (instr_in[15:12] == HALT_OP || pc >= LAST_PC) begin
              state <= HALT;
            end else begin
              pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == RUN);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small behavioural instruction memory.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stall, br_valid;
  logic [12:0] br_target;
  logic [15:0] instr_in;
  logic [12:0] pc, instr_pc;
  logic [15:0] instr_out, fetch_cnt;
  logic        instr_valid, busy, halted, err;

  logic [15:0] mem [0:31];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign instr_in = mem[pc[4:0]];

  fetch_sequencer #(.LAST_ADDR(23), .HALT_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .br_valid(br_valid), .br_target(br_target), .instr_in(instr_in),
    .pc(pc), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .busy(busy), .halted(halted),
    .err(err), .fetch_cnt(fetch_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; tick(); rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;

    // Reset state
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_err", err, 0);

    // 24 NOPs run to end of program
    do_start();
    chk("start_busy", busy, 1);
    chk("start_pc", pc, 0);
    chk("start_valid", instr_valid, 0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("nop_ipc", instr_pc, k - 1);
      chk("nop_valid", instr_valid, 1);
      chk("nop_cnt", fetch_cnt, k);
    end
    chk("eop_halted", halted, 1);
    chk("eop_pc", pc, 23);
    tick();
    chk("eop_valid_drop", instr_valid, 0);
    chk("eop_pc_hold", pc, 23);
    chk("eop_cnt_hold", fetch_cnt, 24);

    // Stall at pc=5 with a redirect pulse inside the stall
    for (int i = 0; i < 32; i++) mem[i] = 16'h0100 + 16'(i);
    do_start();
    for (int k = 0; k < 5; k++) tick();
    chk("pre_stall_pc", pc, 5);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      br_valid = (k == 1); br_target = 13'd10;
      tick();
      chk("stall_pc", pc, 5);
      chk("stall_iout", instr_out, 16'h0104);
      chk("stall_ipc", instr_pc, 4);
      chk("stall_cnt", fetch_cnt, 5);
      chk("stall_valid", instr_valid, 1);
    end
    stall = 1'b0; br_valid = 1'b0;
    tick();
    chk("resume_ipc", instr_pc, 5);
    chk("resume_iout", instr_out, 16'h0105);
    chk("resume_pc", pc, 6);
    chk("resume_cnt", fetch_cnt, 6);

    // start while running is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("run_start_pc", pc, 7);
    chk("run_start_cnt", fetch_cnt, 7);

    // Redirect at pc=4 to 12
    do_reset();
    do_start();
    for (int k = 0; k < 4; k++) tick();
    chk("pre_br_pc", pc, 4);
    br_valid = 1'b1; br_target = 13'd12;
    tick();
    br_valid = 1'b0;
    chk("br_pc", pc, 12);
    chk("br_valid_bubble", instr_valid, 0);
    chk("br_cnt", fetch_cnt, 4);
    tick();
    chk("br_ipc", instr_pc, 12);
    chk("br_iout", instr_out, 16'h010C);
    chk("br_valid_after", instr_valid, 1);
    chk("br_cnt_after", fetch_cnt, 5);

    // Halt opcode at address 7
    mem[7] = 16'hF123;
    do_reset();
    do_start();
    for (int k = 0; k < 8; k++) tick();
    chk("hop_ipc", instr_pc, 7);
    chk("hop_iout", instr_out, 16'hF123);
    chk("hop_valid", instr_valid, 1);
    chk("hop_halted", halted, 1);
    chk("hop_pc", pc, 7);
    chk("hop_cnt", fetch_cnt, 8);
    br_valid = 1'b1; br_target = 13'd3;
    tick();
    br_valid = 1'b0;
    chk("halt_br_ignored_pc", pc, 7);
    chk("halt_valid", instr_valid, 0);
    mem[7] = 16'h0107;
    do_start();
    chk("restart_pc", pc, 0);
    chk("restart_cnt", fetch_cnt, 0);
    chk("restart_busy", busy, 1);

    // Out-of-range redirect
    tick();
    br_valid = 1'b1; br_target = 13'd30;
    tick();
    br_valid = 1'b0;
    chk("oor_err", err, 1);
    chk("oor_halted", halted, 1);
    chk("oor_valid", instr_valid, 0);
    chk("oor_pc", pc, 1);
    do_start();
    chk("oor_err_clr", err, 0);
    chk("oor_restart_pc", pc, 0);

    // Boundary redirect targets: 23 is legal, 24 is not
    br_valid = 1'b1; br_target = 13'd23;
    tick();
    br_valid = 1'b0;
    chk("br23_pc", pc, 23);
    chk("br23_err", err, 0);
    chk("br23_busy", busy, 1);
    tick();
    chk("br23_ipc", instr_pc, 23);
    chk("br23_halted", halted, 1);
    do_start();
    tick();
    br_valid = 1'b1; br_target = 13'd24;
    tick();
    br_valid = 1'b0;
    chk("br24_err", err, 1);
    chk("br24_pc", pc, 1);

    // Reset mid-run with start and stall also asserted
    do_start();
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1; start = 1'b1; stall = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_halted", halted, 0);
    chk("mrst_pc", pc, 0);
    chk("mrst_iout", instr_out, 0);
    chk("mrst_ipc", instr_pc, 0);
    chk("mrst_valid", instr_valid, 0);
    chk("mrst_cnt", fetch_cnt, 0);
    chk("mrst_err", err, 0);
    tick(); tick();
    chk("idle_pc", pc, 0);
    chk("idle_valid", instr_valid, 0);
    chk("idle_cnt", fetch_cnt, 0);

    // Counter saturation: loop addresses 0..20 until the count tops out
    do_start();
    cyc = 0;
    while (fetch_cnt != 16'hFFFF && cyc < 80000) begin
      br_valid = (pc == 13'd20); br_target = 13'd0;
      tick();
      cyc++;
    end
    chk("sat_reached", fetch_cnt, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      br_valid = (pc == 13'd20); br_target = 13'd0;
      tick();
    end
    br_valid = 1'b0;
    chk("sat_hold", fetch_cnt, 16'hFFFF);
    chk("sat_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
